// File: rtl/sramx_xlat_pkg.sv
// Shared constants, types and the kseg0/kseg1 address translation helper
// used by the SRAM-port arbiter front end.
package sramx_xlat_pkg;

  // Physical address mask applied to kseg0/kseg1 virtual addresses.
  localparam logic [31:0] KSEG_MASK  = 32'h1FFF_FFFF;
  // addr[31:30] tag shared by kseg0 and kseg1.
  localparam logic [1:0]  KSEG01_TAG = 2'b10;
  // addr[31:29] tag identifying kseg1 (uncached).
  localparam logic [2:0]  KSEG1_TAG  = 3'b101;

  // Channel id width, sized for the largest supported channel count (8).
  localparam int CH_ID_W = 3;

  // Result of a translation: physical address plus the uncached flag.
  typedef struct packed {
    logic [31:0] phys;
    logic        uncached;
  } xlat_t;

  // One slot of the response pipeline.
  typedef struct packed {
    logic               valid;
    logic [CH_ID_W-1:0] ch_id;
    logic               is_write;
  } rsp_slot_t;

  // Translate a virtual address; with en=0 the address passes through and
  // nothing is reported as uncached.
  function automatic xlat_t xlat(input logic [31:0] addr, input logic en);
    xlat_t r;
    r.phys     = addr;
    r.uncached = 1'b0;
    if (en) begin
      if (addr[31:30] == KSEG01_TAG) begin
        r.phys = addr & KSEG_MASK;
      end
      r.uncached = (addr[31:29] == KSEG1_TAG);
    end
    return r;
  endfunction

endpackage

// File: rtl/sramx_xlat_arbiter_rr.sv
// Round-robin arbiter: combinational grant, registered last-grant pointer.
// Priority starts one above the last granted channel and wraps upward.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [N-1:0]                          req,
  input  logic                                  advance,
  output logic [N-1:0]                          grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  grant_idx,
  output logic                                  grant_any
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  // Search the requests starting just above the last grant, with wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr_reg) + 1 + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (!grant_any && req[cand_idx]) begin
        grant_any       = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

  // The pointer moves only when a grant is actually taken.
  always_comb begin
    ptr_next = ptr_reg;
    if (advance && grant_any) begin
      ptr_next = grant_idx;
    end
  end

  // Reset parks the pointer on the last channel so channel 0 wins first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_reg <= IDX_W'(N - 1);
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/sramx_xlat_arbiter.sv
// SRAM-port front end: arbitrates N_CH request channels onto one SRAM port,
// translates kseg0/kseg1 addresses, and routes each response back to its
// requester through an RD_LAT-deep tracking pipeline.
module sramx_xlat_arbiter
  import sramx_xlat_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1,
  parameter int XLAT_EN = 1
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [N_CH-1:0]                     ch_req,
  input  logic [N_CH-1:0][DATA_W/8-1:0]       ch_wen,
  input  logic [N_CH-1:0][31:0]               ch_addr,
  input  logic [N_CH-1:0][DATA_W-1:0]         ch_wdata,
  output logic [N_CH-1:0]                     ch_addr_ok,
  output logic [N_CH-1:0]                     ch_data_ok,
  output logic [N_CH-1:0][DATA_W-1:0]         ch_rdata,
  output logic [N_CH-1:0]                     ch_uncached,
  output logic                                sram_en,
  output logic [DATA_W/8-1:0]                 sram_wen,
  output logic [31:0]                         sram_addr,
  output logic [DATA_W-1:0]                   sram_wdata,
  input  logic [DATA_W-1:0]                   sram_rdata
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0][31:0] phys;
  logic [N_CH-1:0]       uncached_raw;
  logic [N_CH-1:0]       grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  grant_live;

  rsp_slot_t                slot_in;
  rsp_slot_t [RD_LAT-1:0]   slot_reg;
  rsp_slot_t                rsp_out;

  // Per-channel translation; the uncached flag is visible even without a grant.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_xlat
    xlat_t x;
    assign x                = xlat(ch_addr[gi], XLAT_EN != 0);
    assign phys[gi]         = x.phys;
    assign uncached_raw[gi] = x.uncached;
  end

  assign ch_uncached = uncached_raw;

  rr_arbiter #(
    .N (N_CH)
  ) u_rr (
    .clk       (clk),
    .resetn    (resetn),
    .req       (ch_req),
    .advance   (resetn),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Reset masks the grant combinationally so nothing leaks out while low.
  assign grant_live = resetn & grant_any;
  assign ch_addr_ok = resetn ? grant : '0;

  // Steer the granted channel onto the SRAM port.
  always_comb begin
    sram_en    = grant_live;
    sram_wen   = grant_live ? ch_wen[grant_idx] : '0;
    sram_addr  = phys[grant_idx];
    sram_wdata = ch_wdata[grant_idx];
  end

  // Describe the transaction entering the response pipeline this cycle.
  always_comb begin
    slot_in          = '0;
    slot_in.valid    = grant_live;
    slot_in.ch_id    = CH_ID_W'(grant_idx);
    slot_in.is_write = |sram_wen;
  end

  // Shift the response tracker; reset discards everything in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_reg <= '0;
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) begin
        slot_reg[k] <= slot_reg[k-1];
      end
      slot_reg[0] <= slot_in;
    end
  end

  assign rsp_out = slot_reg[RD_LAT-1];

  // Route the completing response to its channel; writes return zero data.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_rsp
    assign ch_data_ok[gi] = resetn & rsp_out.valid & (rsp_out.ch_id == CH_ID_W'(gi));
    assign ch_rdata[gi]   = (ch_data_ok[gi] && !rsp_out.is_write) ? sram_rdata : '0;
  end

endmodule

// File: doc/sramx_xlat_arbiter.md
# sramx_xlat_arbiter

Parametrised SRAM-port front end. It arbitrates N_CH SRAM-style request channels (instruction, data, future DMA/debug) onto one physical SRAM port, applying MIPS kseg0/kseg1 virtual-to-physical translation. It tracks each read through a RD_LAT-deep response pipeline and returns data to the originating channel with an addr_ok/data_ok handshake. It sits between the core bus converters and the board SRAM interface, replacing per-channel direct wiring.

## Interface
Parameters:
- N_CH, 2, number of request channels (1..8)
- DATA_W, 32, data width; byte enables are DATA_W/8
- RD_LAT, 1, SRAM read latency in cycles (1..3)
- XLAT_EN, 1, 1 = kseg0/kseg1 translation; 0 = identity

Ports:
- clk  in  1  clock
- resetn  in  1  reset; one clock, asynchronous active-low reset
- ch_req  in  N_CH  per-channel request valid
- ch_wen  in  N_CH×(DATA_W/8)  byte write enables; nonzero means write
- ch_addr  in  N_CH×32  virtual address
- ch_wdata  in  N_CH×DATA_W  write data
- ch_addr_ok  out  N_CH  request accepted this cycle (one-hot or zero)
- ch_data_ok  out  N_CH  response pulse (one-hot or zero)
- ch_rdata  out  N_CH×DATA_W  read data, valid with ch_data_ok
- ch_uncached  out  N_CH  requested address is in kseg1
- sram_en  out  1  SRAM enable
- sram_wen  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  32  physical address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, RD_LAT cycles after sram_en

## Operation
- **Arbitration:** round-robin. Priority starts at channel (last_grant+1) mod N_CH and searches upward with wrap. The pointer updates only on a grant.
- **Grant timing:** combinational in the same cycle. Granted channel gets ch_addr_ok=1. sram_en=1 and sram_wen/addr/wdata are taken from that channel.
- **No request:** sram_en=0 and sram_wen=0.
- **Translation (XLAT_EN=1):**
  - addr[31:30]==2'b10 (0x8000_0000–0xBFFF_FFFF): phys = addr & 0x1FFF_FFFF.
  - Otherwise phys = addr.
  - ch_uncached[i] = (addr[31:29]==3'b101), combinational per channel regardless of grant.
- **Translation (XLAT_EN=0):** phys = addr; ch_uncached=0.
- **Response pipeline:** RD_LAT stages of {valid, ch_id, is_write}.
  - Stage 0 loads on every grant.
  - At the final stage, ch_data_ok[ch_id] pulses for one cycle.
  - ch_rdata[ch_id] = sram_rdata for reads; 0 for writes. ch_rdata of non-responding channels is 0.
- **Ordering and backpressure:** responses are in grant order. No backpressure: requesters must accept data_ok whenever it pulses.
- **Outstanding limit:** at most RD_LAT transactions in flight; one grant per cycle is always accepted.
- **Holding:** a requester holds ch_req/addr/wen/wdata stable until it sees addr_ok.

## Timing
- **Reset (resetn low, asynchronous):**
  - rr pointer = N_CH-1, so channel 0 has first priority.
  - All pipeline valids = 0.
  - ch_addr_ok, ch_data_ok, sram_en, sram_wen are forced 0 while resetn=0; ch_rdata = 0.
- **Reset mid-operation:** in-flight responses are discarded and no data_ok is issued for them. The first grant after reset release goes to the lowest-index requester.
- **Latency:** request→addr_ok is 0 cycles; addr_ok→data_ok is RD_LAT cycles.
- **Back-to-back:** a lone requester is granted every cycle, giving throughput of 1 transfer/cycle.
- **Contention:** with all N_CH requesting, each channel is granted exactly once per N_CH cycles.
- **Simultaneous events:** a new grant and a completing response in the same cycle are independent. data_ok may coincide with addr_ok on the same or a different channel.

## Structure
- Package sramx_xlat_pkg:
  - constants KSEG_MASK=32'h1FFF_FFFF, KSEG01_TAG=2'b10, KSEG1_TAG=3'b101
  - function xlat(addr, en) returning {phys, uncached}
  - typedef rsp_slot_t {valid, ch_id[$clog2(N_CH)], is_write}
- Sub-module rr_arbiter (parameter N):
  - inputs req[N] and advance
  - output grant one-hot
  - contains the registered pointer with asynchronous active-low reset
- Top module: mux, translation, response shift pipeline.

## Test plan
- **Translation:** ch0 read 0xBFC0_0010 → sram_addr=0x1FC0_0010, ch_uncached[0]=1; addr 0x9000_0004 → 0x1000_0004, uncached=0; 0x0040_0000 → unchanged. With XLAT_EN=0, all addresses pass through unchanged.
- **Read latency:** RD_LAT=2, ch1 reads 0x0000_0100 with SRAM returning 0xDEAD_BEEF two cycles later → ch_data_ok[1] exactly 2 cycles after addr_ok, ch_rdata[1]=0xDEAD_BEEF.
- **Round-robin:** N_CH=3, all channels request continuously for 6 cycles → grants 0,1,2,0,1,2; each data_ok returns to the correct channel in grant order.
- **Write response:** ch0 writes wen=4'b0011, wdata=0x1234_5678 → sram_wen=4'b0011; data_ok[0] after RD_LAT cycles with rdata=0.
- **Async reset mid-flight:** assert resetn low between grant and data_ok → no data_ok is ever issued for that transaction. Outputs are 0 immediately, before the next clk edge. After release, simultaneous ch0/ch1 requests → ch0 granted first.
